// File: rtl/pc_sequencer.sv
// Next-PC sequencer for the fetch stage: flush, halt, redirect, stall, advance.
// Holds drain bubbles after a flush, a halted state and a redirect counter.
module pc_sequencer #(
   parameter int XLEN = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int FETCH_BYTES = 4,
   parameter int FLUSH_BUBBLE = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [XLEN-1:0]  pc_current,
   input  logic             flush_valid,
   input  logic [XLEN-1:0]  flush_target,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_target,
   input  logic             stall,
   input  logic             halt_req,
   output logic [XLEN-1:0]  pc_next,
   output logic             pc_write,
   output logic             fetch_valid,
   output logic             halted,
   output logic             misalign_err,
   output logic [CNT_W-1:0] redirect_count
);

   localparam logic [XLEN-1:0] OFF_MASK = XLEN'(FETCH_BYTES - 1);
   localparam logic [XLEN-1:0] STEP     = XLEN'(FETCH_BYTES);
   localparam logic [3:0]      BUBBLE   = 4'(FLUSH_BUBBLE);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t           state;
   logic [3:0]       bubble_cnt;
   logic [XLEN-1:0]  flush_pc;
   logic [XLEN-1:0]  redir_pc;
   logic             flush_mis;
   logic             redir_mis;
   logic             redir_take;
   logic [CNT_W-1:0] count_inc;

   assign flush_pc   = flush_target & ~OFF_MASK;
   assign redir_pc   = redirect_target & ~OFF_MASK;
   assign flush_mis  = |(flush_target & OFF_MASK);
   assign redir_mis  = |(redirect_target & OFF_MASK);
   assign redir_take = (state == RUN) && !halt_req && redirect_valid;
   assign count_inc  = (&redirect_count) ? redirect_count
                                         : redirect_count + CNT_W'(1);

   // Next-PC select: reset forces, then flush, then RUN-state priorities.
   always_comb begin
      pc_next     = pc_current;
      pc_write    = 1'b0;
      fetch_valid = 1'b0;
      if (!reset) begin
         pc_next = RESET_PC;
      end else if (flush_valid) begin
         pc_next  = flush_pc;
         pc_write = 1'b1;
      end else if (state == RUN) begin
         priority case (1'b1)
            halt_req: begin
               pc_write = 1'b0;
            end
            redirect_valid: begin
               pc_next  = redir_pc;
               pc_write = 1'b1;
            end
            stall: begin
               pc_write = 1'b0;
            end
            default: begin
               pc_next     = pc_current + STEP;
               pc_write    = 1'b1;
               fetch_valid = 1'b1;
            end
         endcase
      end
   end

   // Sequencer state, bubble countdown, halted flag, error pulse and counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= RUN;
         bubble_cnt     <= 4'd0;
         halted         <= 1'b0;
         misalign_err   <= 1'b0;
         redirect_count <= '0;
      end else begin
         misalign_err <= 1'b0;
         if (flush_valid) begin
            misalign_err   <= flush_mis;
            redirect_count <= count_inc;
            halted         <= 1'b0;
            if (BUBBLE != 4'd0) begin
               state      <= DRAIN;
               bubble_cnt <= BUBBLE;
            end else begin
               state      <= RUN;
               bubble_cnt <= 4'd0;
            end
         end else begin
            case (state)
               RUN: begin
                  if (halt_req) begin
                     state  <= HALTED;
                     halted <= 1'b1;
                  end else if (redir_take) begin
                     misalign_err   <= redir_mis;
                     redirect_count <= count_inc;
                  end
               end
               DRAIN: begin
                  if (bubble_cnt <= 4'd1) begin
                     state      <= RUN;
                     bubble_cnt <= 4'd0;
                  end else begin
                     bubble_cnt <= bubble_cnt - 4'd1;
                  end
               end
               HALTED: begin
                  halted <= 1'b1;
               end
               default: begin
                  state <= RUN;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential advance, wrap, redirect,
// flush drain, halt, misalignment and mid-drain reset.
module tb_pc_sequencer;

   logic        clk;
   logic        reset;
   logic [31:0] pc_current;
   logic        flush_valid;
   logic [31:0] flush_target;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        stall;
   logic        halt_req;
   logic [31:0] pc_next;
   logic        pc_write;
   logic        fetch_valid;
   logic        halted;
   logic        misalign_err;
   logic [15:0] redirect_count;

   logic        loopback;
   logic [31:0] pc_reg;
   logic [31:0] pc_drv;
   int          checks;
   int          failures;

   pc_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .pc_current      (pc_current),
      .flush_valid     (flush_valid),
      .flush_target    (flush_target),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .stall           (stall),
      .halt_req        (halt_req),
      .pc_next         (pc_next),
      .pc_write        (pc_write),
      .fetch_valid     (fetch_valid),
      .halted          (halted),
      .misalign_err    (misalign_err),
      .redirect_count  (redirect_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PC register model fed back from the sequencer.
   always @(posedge clk or negedge reset) begin
      if (!reset) pc_reg <= 32'h0;
      else if (pc_write) pc_reg <= pc_next;
   end

   assign pc_current = loopback ? pc_reg : pc_drv;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush_valid    = 1'b0;
      redirect_valid = 1'b0;
      stall          = 1'b0;
      halt_req       = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b0;
      loopback = 1'b0;
      pc_drv = 32'h0;
      flush_target = 32'h0;
      redirect_target = 32'h0;
      idle();

      #2;
      flush_valid = 1'b1;
      flush_target = 32'h80;
      #1;
      chk("rst_pc_next", pc_next, 32'h0);
      chk("rst_pc_write", 32'(pc_write), 32'h0);
      chk("rst_fetch_valid", 32'(fetch_valid), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_misalign", 32'(misalign_err), 32'h0);
      chk("rst_count", 32'(redirect_count), 32'h0);
      idle();
      tick();
      tick();

      reset = 1'b1;
      loopback = 1'b1;
      #1;
      chk("seq0_pc_next", pc_next, 32'h4);
      chk("seq0_pc_write", 32'(pc_write), 32'h1);
      chk("seq0_fetch_valid", 32'(fetch_valid), 32'h1);
      repeat (4) tick();
      chk("seq4_pc", pc_reg, 32'h10);
      chk("seq4_pc_next", pc_next, 32'h14);

      loopback = 1'b0;
      pc_drv = 32'hFFFF_FFFC;
      #1;
      chk("wrap_pc_next", pc_next, 32'h0);
      chk("wrap_pc_write", 32'(pc_write), 32'h1);

      stall = 1'b1;
      pc_drv = 32'h80;
      #1;
      chk("stall_pc_next", pc_next, 32'h80);
      chk("stall_pc_write", 32'(pc_write), 32'h0);

      redirect_valid = 1'b1;
      redirect_target = 32'h100;
      #1;
      chk("redir_pc_next", pc_next, 32'h100);
      chk("redir_pc_write", 32'(pc_write), 32'h1);
      chk("redir_fetch_valid", 32'(fetch_valid), 32'h0);
      tick();
      idle();
      pc_drv = 32'h100;
      #1;
      chk("redir_count", 32'(redirect_count), 32'h1);
      chk("redir_misalign", 32'(misalign_err), 32'h0);

      flush_valid = 1'b1;
      flush_target = 32'h200;
      redirect_valid = 1'b1;
      redirect_target = 32'h300;
      #1;
      chk("flush_pc_next", pc_next, 32'h200);
      chk("flush_pc_write", 32'(pc_write), 32'h1);
      chk("flush_fetch_valid", 32'(fetch_valid), 32'h0);
      tick();
      idle();
      pc_drv = 32'h200;
      redirect_valid = 1'b1;
      redirect_target = 32'h300;
      #1;
      chk("drain1_pc_write", 32'(pc_write), 32'h0);
      chk("drain1_fetch_valid", 32'(fetch_valid), 32'h0);
      chk("drain1_pc_next", pc_next, 32'h200);
      chk("drain1_count", 32'(redirect_count), 32'h2);
      tick();
      idle();
      #1;
      chk("drain2_pc_write", 32'(pc_write), 32'h0);
      chk("drain2_count", 32'(redirect_count), 32'h2);
      tick();
      chk("resume_pc_write", 32'(pc_write), 32'h1);
      chk("resume_fetch_valid", 32'(fetch_valid), 32'h1);
      chk("resume_pc_next", pc_next, 32'h204);

      pc_drv = 32'h204;
      halt_req = 1'b1;
      redirect_valid = 1'b1;
      redirect_target = 32'h300;
      #1;
      chk("halt_pc_write", 32'(pc_write), 32'h0);
      chk("halt_pc_next", pc_next, 32'h204);
      tick();
      halt_req = 1'b0;
      #1;
      chk("halted_flag", 32'(halted), 32'h1);
      chk("halted_pc_write", 32'(pc_write), 32'h0);
      chk("halted_fetch_valid", 32'(fetch_valid), 32'h0);
      tick();
      chk("halted_hold", 32'(halted), 32'h1);
      chk("halted_count", 32'(redirect_count), 32'h2);
      redirect_valid = 1'b0;
      flush_valid = 1'b1;
      flush_target = 32'h40;
      #1;
      chk("unhalt_pc_next", pc_next, 32'h40);
      chk("unhalt_pc_write", 32'(pc_write), 32'h1);
      tick();
      idle();
      #1;
      chk("unhalt_halted", 32'(halted), 32'h0);
      chk("unhalt_count", 32'(redirect_count), 32'h3);

      flush_valid = 1'b1;
      flush_target = 32'h202;
      #1;
      chk("mis_pc_next", pc_next, 32'h200);
      tick();
      idle();
      #1;
      chk("mis_pulse", 32'(misalign_err), 32'h1);
      chk("mis_count", 32'(redirect_count), 32'h4);
      chk("mis_drain_pc_write", 32'(pc_write), 32'h0);
      tick();
      chk("mis_clear", 32'(misalign_err), 32'h0);
      tick();

      flush_valid = 1'b1;
      flush_target = 32'h300;
      tick();
      idle();
      pc_drv = 32'h300;
      #1;
      chk("flush3_misalign", 32'(misalign_err), 32'h0);
      chk("flush3_pc_write", 32'(pc_write), 32'h0);
      chk("flush3_count", 32'(redirect_count), 32'h5);
      reset = 1'b0;
      #1;
      chk("rst2_pc_next", pc_next, 32'h0);
      chk("rst2_pc_write", 32'(pc_write), 32'h0);
      reset = 1'b1;
      #1;
      chk("rst2_run_pc_write", 32'(pc_write), 32'h1);
      chk("rst2_run_fetch_valid", 32'(fetch_valid), 32'h1);
      chk("rst2_run_pc_next", pc_next, 32'h304);
      chk("rst2_count", 32'(redirect_count), 32'h0);
      tick();
      chk("rst2_after_pc_write", 32'(pc_write), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
